// File: rtl/cpu_joypad_port.sv
// CPU-bus responder for the two controller ports at $4016/$4017: strobe latch,
// button synchronizers and the two serial shift registers read one bit per access.
module cpu_joypad_port #(
  parameter logic [7:0]  OPEN_BUS  = 8'h40,
  parameter logic [15:0] PAD1_ADDR = 16'h4016,
  parameter logic [15:0] PAD2_ADDR = 16'h4017
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ce,
  input  logic [15:0] addr,
  input  logic [7:0]  wdata,
  input  logic        mr,
  input  logic        mw,
  output logic [7:0]  rdata,
  output logic        hit,
  input  logic [7:0]  pad1_btn,
  input  logic [7:0]  pad2_btn
);

  logic [7:0] pad1_meta_q, pad1_meta_d;
  logic [7:0] pad1_sync_q, pad1_sync_d;
  logic [7:0] pad2_meta_q, pad2_meta_d;
  logic [7:0] pad2_sync_q, pad2_sync_d;
  logic       strobe_q, strobe_d;
  logic [7:0] sh1_q, sh1_d;
  logic [7:0] sh2_q, sh2_d;

  logic sel1, sel2;
  logic serial_bit;
  logic unused_wdata;

  assign unused_wdata = ^wdata[7:1];

  always_comb begin
    sel1 = (addr == PAD1_ADDR);
    sel2 = (addr == PAD2_ADDR);
    hit  = mr & (sel1 | sel2);

    // Synchronizers run every clk, independent of ce.
    pad1_meta_d = pad1_btn;
    pad1_sync_d = pad1_meta_q;
    pad2_meta_d = pad2_btn;
    pad2_sync_d = pad2_meta_q;

    strobe_d = strobe_q;
    sh1_d    = sh1_q;
    sh2_d    = sh2_q;

    if (ce) begin
      // Reload keys off the registered strobe, so the clearing write still loads.
      if (strobe_q) begin
        sh1_d = pad1_sync_q;
        sh2_d = pad2_sync_q;
      end else if (mr && !mw) begin
        if (sel1) sh1_d = {1'b1, sh1_q[7:1]};
        if (sel2) sh2_d = {1'b1, sh2_q[7:1]};
      end
      if (mw && sel1) strobe_d = wdata[0];
    end

    if (sel2) serial_bit = strobe_q ? pad2_sync_q[0] : sh2_q[0];
    else      serial_bit = strobe_q ? pad1_sync_q[0] : sh1_q[0];

    rdata = hit ? {OPEN_BUS[7:1], serial_bit} : OPEN_BUS;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pad1_meta_q <= '0;
      pad1_sync_q <= '0;
      pad2_meta_q <= '0;
      pad2_sync_q <= '0;
      strobe_q    <= 1'b0;
      sh1_q       <= '0;
      sh2_q       <= '0;
    end else begin
      pad1_meta_q <= pad1_meta_d;
      pad1_sync_q <= pad1_sync_d;
      pad2_meta_q <= pad2_meta_d;
      pad2_sync_q <= pad2_sync_d;
      strobe_q    <= strobe_d;
      sh1_q       <= sh1_d;
      sh2_q       <= sh2_d;
    end
  end

endmodule

// File: doc/cpu_joypad_port.md
Name: cpu_joypad_port

Overview:
- CPU-bus responder for the two NES controller ports at $4016/$4017. It is the slave side of the CPU's aout/dout/mr/mw/DIN bus.
- Decodes CPU accesses, latches the strobe bit on writes to $4016, and parallel-loads two 8-bit shift registers from the synchronized pad button states.
- Returns one serial button bit per read and shifts on each read.
- Its read data is muxed into the CPU DIN path by the top-level bus mux whenever `hit` is high.

Parameters:
- OPEN_BUS, 8'h40, value driven on read-data bits 7:1 (bit 0 is replaced by the serial bit).
- PAD1_ADDR, 16'h4016, address of port 1 (strobe write and pad 1 read).
- PAD2_ADDR, 16'h4017, address of port 2 read (writes to it are ignored by this block).

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- ce  in  1  CPU clock enable; all bus-side state updates only when ce=1
- addr  in  16  CPU address (aout)
- wdata  in  8  CPU write data (dout)
- mr  in  1  CPU read strobe
- mw  in  1  CPU write strobe
- rdata  out  8  read data to DIN mux
- hit  out  1  1 when mr=1 and addr is PAD1_ADDR or PAD2_ADDR (combinational, independent of ce)
- pad1_btn  in  8  pad 1 buttons, active-high pressed, asynchronous; bit0=A, 1=B, 2=Select, 3=Start, 4=Up, 5=Down, 6=Left, 7=Right
- pad2_btn  in  8  pad 2 buttons, same encoding

Behaviour:
- Synchronizer:
  - pad1_btn and pad2_btn each pass through 2 flops clocked every clk, not gated by ce. This gives sync1/sync2 with 2-clk latency.
  - Reset sets the synchronizers to 0.
- Strobe:
  - Register strobe, reset 0.
  - On ce & mw & addr==PAD1_ADDR: strobe <= wdata[0]. wdata[7:1] are ignored.
  - A write to PAD2_ADDR changes nothing.
- Shift registers sh1, sh2 (8 bits each, reset 8'h00), updated on ce cycles only:
  - Priority 1, reload: if the current registered strobe==1, then sh1<=sync1 and sh2<=sync2. This includes the ce cycle in which a write clears strobe, so the last load happens at strobe fall.
  - Priority 2, shift: else if mr & addr==PAD1_ADDR, then sh1 <= {1'b1, sh1[7:1]}. Likewise mr & addr==PAD2_ADDR shifts sh2.
  - Only the addressed register shifts. The other register holds.
- Read data (combinational, valid whenever hit=1):
  - Serial bit b = strobe ? syncN[0] : shN[0], where N is the addressed port.
  - rdata = {OPEN_BUS[7:1], b}.
  - When hit=0, rdata = OPEN_BUS.
- Read side effects:
  - Every ce cycle with mr=1 at a port address is one read and shifts once. CPU dummy reads (e.g. indexed RMW) therefore consume bits; this is required behaviour.
  - While strobe=1, reads return the live A button and never shift.
- Boundary conditions:
  - After 8 reads with strobe=0, sh holds 8'hFF. Every further read returns bit0=1 until the next reload.
  - ce=0: no state change except the synchronizers. rdata and hit still track the inputs.
  - Simultaneous mw and mr cannot occur (mr = !mw). If both are driven high, the write takes precedence and no shift occurs.
  - Reset mid-sequence returns strobe, sh1, sh2 and the synchronizers to 0. Reads then return bit0=0 until the next strobe.

Test Plan:
- Reset, then read $4016 with ce=1 -> rdata=8'h40, hit=1. Read $4020 -> hit=0, rdata=8'h40.
- pad1_btn=8'b1000_0101 held ≥2 clk; write $4016=1 then $4016=0; 10 reads of $4016 -> bit0 sequence 1,0,1,0,0,0,0,1,1,1.
- Strobe held at 1; pad1_btn toggles bit0 0→1; 3 reads -> each read returns the current synced A (1 after 2 clk). A later strobe-0 read sequence is unaffected by those reads.
- pad1=8'h01, pad2=8'h02; strobe cycle; read $4017 twice, then $4016 once -> $4017 gives 0,1; $4016 gives 1 (sh1 unshifted by port 2 reads).
- Read $4016 with ce=0 for 5 cycles after strobe -> no shift; the first ce read returns bit 0 of the pad. Write $4017=1 -> strobe stays 0.
- Assert reset after 3 reads -> next read returns 0. Then strobe/unstrobe with pad1=8'hFF -> 8 reads return 1.
